// File: rtl/riscv_branch_pkg.sv
// Shared constants for the RV64I branch resolver: condition codes, FSM encoding
// and a helper that classifies reserved funct3 values.
package riscv_branch_pkg;

    localparam int XLEN_DEF        = 64;
    localparam int INSTR_BYTES_DEF = 4;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_TGT  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // 010 and 011 are the only unassigned branch encodings.
    function automatic logic is_reserved_f3(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Maps funct3 plus the ALU compare flags onto the branch decision.
module branch_cond_eval
    import riscv_branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       alu_eq,
    input  logic       alu_ne,
    input  logic       alu_lt,
    input  logic       alu_ge,
    input  logic       alu_ltu,
    input  logic       alu_geu,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = is_reserved_f3(funct3);
        case (funct3)
            F3_BEQ:  taken = alu_eq;
            F3_BNE:  taken = alu_ne;
            F3_BLT:  taken = alu_lt;
            F3_BGE:  taken = alu_ge;
            F3_BLTU: taken = alu_ltu;
            F3_BGEU: taken = alu_geu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_seq.sv
// Four-state branch resolver that borrows the shared ALU twice: once to compare
// rs1/rs2, once to add the target or fall-through offset to pc.
module branch_resolve_seq
    import riscv_branch_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic            alu_sum_sub,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_eq,
    input  logic            alu_ne,
    input  logic            alu_lt,
    input  logic            alu_ge,
    input  logic            alu_ltu,
    input  logic            alu_geu,
    output logic            busy,
    output logic            done,
    output logic            taken,
    output logic            illegal,
    output logic [XLEN-1:0] next_pc
);

    logic [1:0]      state_reg, state_next;
    logic [2:0]      funct3_reg;
    logic [XLEN-1:0] rs1_reg, rs2_reg, pc_reg, imm_reg;
    logic            cond_taken_reg, cond_illegal_reg;
    logic            taken_reg, illegal_reg;
    logic [XLEN-1:0] next_pc_reg;
    logic            eval_taken, eval_illegal;

    branch_cond_eval u_cond (
        .funct3  (funct3_reg),
        .alu_eq  (alu_eq),
        .alu_ne  (alu_ne),
        .alu_lt  (alu_lt),
        .alu_ge  (alu_ge),
        .alu_ltu (alu_ltu),
        .alu_geu (alu_geu),
        .taken   (eval_taken),
        .illegal (eval_illegal)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_CMP;
            ST_CMP:  state_next = ST_TGT;
            ST_TGT:  state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_sum_sub = 1'b0;
        case (state_reg)
            ST_CMP: begin
                alu_a       = rs1_reg;
                alu_b       = rs2_reg;
                alu_sum_sub = 1'b1;
            end
            ST_TGT: begin
                alu_a = pc_reg;
                alu_b = cond_taken_reg ? imm_reg : XLEN'(INSTR_BYTES);
            end
            default: ;
        endcase
    end

    // Visible results only move at the TGT edge so they stay coherent with next_pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            funct3_reg       <= '0;
            rs1_reg          <= '0;
            rs2_reg          <= '0;
            pc_reg           <= '0;
            imm_reg          <= '0;
            cond_taken_reg   <= 1'b0;
            cond_illegal_reg <= 1'b0;
            taken_reg        <= 1'b0;
            illegal_reg      <= 1'b0;
            next_pc_reg      <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        funct3_reg <= funct3;
                        rs1_reg    <= rs1_val;
                        rs2_reg    <= rs2_val;
                        pc_reg     <= pc;
                        imm_reg    <= imm;
                    end
                end
                ST_CMP: begin
                    cond_taken_reg   <= eval_taken;
                    cond_illegal_reg <= eval_illegal;
                end
                ST_TGT: begin
                    taken_reg   <= cond_taken_reg;
                    illegal_reg <= cond_illegal_reg;
                    next_pc_reg <= alu_result;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign taken   = taken_reg;
    assign illegal = illegal_reg;
    assign next_pc = next_pc_reg;

endmodule

// File: tb/tb_branch_resolve_seq.sv
// Scoreboard bench: a behavioural branch model fills an expectation queue, a
// negedge monitor pops and compares on every done pulse.
module tb_branch_resolve_seq;

    localparam int XL = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    funct3 = '0;
    logic [XL-1:0] rs1_val = '0, rs2_val = '0, pc = '0, imm = '0;
    logic [XL-1:0] alu_a, alu_b, alu_result, next_pc;
    logic          alu_sum_sub, alu_eq, alu_ne, alu_lt, alu_ge, alu_ltu, alu_geu;
    logic          busy, done, taken, illegal;

    branch_resolve_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc), .imm(imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sum_sub(alu_sum_sub),
        .alu_result(alu_result), .alu_eq(alu_eq), .alu_ne(alu_ne),
        .alu_lt(alu_lt), .alu_ge(alu_ge), .alu_ltu(alu_ltu), .alu_geu(alu_geu),
        .busy(busy), .done(done), .taken(taken), .illegal(illegal),
        .next_pc(next_pc)
    );

    // Shared adder ALU with compare flags
    assign alu_result = alu_sum_sub ? (alu_a - alu_b) : (alu_a + alu_b);
    assign alu_eq  = (alu_a == alu_b);
    assign alu_ne  = (alu_a != alu_b);
    assign alu_lt  = ($signed(alu_a) < $signed(alu_b));
    assign alu_ge  = ($signed(alu_a) >= $signed(alu_b));
    assign alu_ltu = (alu_a < alu_b);
    assign alu_geu = (alu_a >= alu_b);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic          taken;
        logic          illegal;
        logic [XL-1:0] npc;
        int            done_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;

    task automatic check(input string name, input logic [XL-1:0] act, input logic [XL-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t ref_model(input logic [2:0] f3, input logic [XL-1:0] a,
                                       input logic [XL-1:0] b, input logic [XL-1:0] p,
                                       input logic [XL-1:0] i);
        exp_t e;
        e.taken    = 1'b0;
        e.illegal  = 1'b0;
        e.done_cyc = 0;
        case (f3)
            3'd0: e.taken = (a == b);
            3'd1: e.taken = (a != b);
            3'd4: e.taken = ($signed(a) < $signed(b));
            3'd5: e.taken = ($signed(a) >= $signed(b));
            3'd6: e.taken = (a < b);
            3'd7: e.taken = (a >= b);
            default: e.illegal = 1'b1;
        endcase
        e.npc = p + (e.taken ? i : 64'd4);
        return e;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_alu_a"}, alu_a, '0);
        check({tag, "_alu_b"}, alu_b, '0);
        check({tag, "_sum_sub"}, {63'd0, alu_sum_sub}, '0);
        check({tag, "_busy"}, {63'd0, busy}, '0);
        check({tag, "_done"}, {63'd0, done}, '0);
        check({tag, "_taken"}, {63'd0, taken}, '0);
        check({tag, "_illegal"}, {63'd0, illegal}, '0);
        check({tag, "_next_pc"}, next_pc, '0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] f3, input logic [XL-1:0] a, input logic [XL-1:0] b,
                         input logic [XL-1:0] p, input logic [XL-1:0] i);
        exp_t e;
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("idle_timeout", {63'd0, busy}, '0);
        funct3 = f3; rs1_val = a; rs2_val = b; pc = p; imm = i;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        funct3 = 3'($urandom);
        rs1_val = {$urandom, $urandom}; rs2_val = {$urandom, $urandom};
        pc = {$urandom, $urandom}; imm = {$urandom, $urandom};
        e = ref_model(f3, a, b, p, i);
        e.done_cyc = cyc + 2;
        exp_q.push_back(e);
        last_exp = e;
        @(negedge clk);
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 cycle=%0d", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("done cycle=%0d taken=%0b illegal=%0b next_pc=%h", cyc, taken, illegal, next_pc);
                check("taken", {63'd0, taken}, {63'd0, e.taken});
                check("illegal", {63'd0, illegal}, {63'd0, e.illegal});
                check("next_pc", next_pc, e.npc);
                check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                check("busy_in_done", {63'd0, busy}, 64'd1);
                check("alu_a_in_done", alu_a, '0);
                check("alu_sum_sub_in_done", {63'd0, alu_sum_sub}, '0);
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), '0);
    endtask

    initial begin
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        // beq taken
        issue(3'b000, 64'd5, 64'd5, 64'h1000, 64'h20);
        drain();
        repeat (3) @(negedge clk);
        check("hold_beq_next_pc", next_pc, 64'h1020);
        check("hold_beq_taken", {63'd0, taken}, 64'd1);

        // bltu vs blt
        issue(3'b110, 64'd1, '1, 64'h200, 64'h40);
        issue(3'b100, 64'd1, '1, 64'h200, 64'h40);
        drain();
        check("blt_fallthrough", next_pc, 64'h204);

        // illegal funct3
        issue(3'b011, 64'd7, 64'd7, 64'h80, 64'h100);
        drain();
        check("illegal_flag", {63'd0, illegal}, 64'd1);

        // negative imm, wrap-around fall-through
        issue(3'b001, 64'd3, 64'd4, 64'h10, -64'sd32);
        drain();
        check("neg_imm_next_pc", next_pc, 64'hFFFF_FFFF_FFFF_FFF0);
        issue(3'b000, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40);
        drain();
        check("wrap_next_pc", next_pc, 64'd0);

        // start held through CMP/TGT/DONE must be ignored
        issue(3'b101, 64'd9, 64'd2, 64'h3000, 64'h8);
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            funct3 = 3'b001; rs1_val = 64'd1; rs2_val = 64'd2;
            pc = 64'h7777_0000; imm = 64'h1234;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_ignore_queue", 64'(exp_q.size()), '0);
        check("busy_ignore_next_pc", next_pc, 64'h3008);

        // reset during TGT
        issue(3'b001, 64'd1, 64'd2, 64'h4000, 64'h100);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midop_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3'b111, 64'd10, 64'd3, 64'h5000, 64'h10);
        drain();
        check("after_reset_next_pc", next_pc, 64'h5010);

        // randomized traffic
        for (int t = 0; t < 150; t++) begin
            logic [2:0]    f3;
            logic [XL-1:0] a, b, p, i;
            logic [12:0]   off;
            f3  = 3'($urandom);
            a   = {$urandom, $urandom};
            b   = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = a ^ 64'h8000_0000_0000_0000;
            p   = {$urandom, $urandom} & ~64'h3;
            off = 13'($urandom) & ~13'h1;
            i   = XL'($signed(off));
            issue(f3, a, b, p, i);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        repeat (4) @(negedge clk);
        check("final_hold_next_pc", next_pc, last_exp.npc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
